// File: rtl/bus_xfer_ctrl.sv
// Bus transfer controller: enables one source onto the shared bus, captures the
// bus word, then strobes the selected destination's load input.
module bus_xfer_ctrl #(
  parameter int W     = 8,
  parameter int N_SRC = 4,
  parameter int N_DST = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] src,
  input  logic [SEL_W-1:0] dst,
  input  logic [W-1:0]     bus_in,
  output logic [N_SRC-1:0] oe,
  output logic [N_DST-1:0] ld,
  output logic [W-1:0]     data_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_LOAD    = 2'd3
  } state_t;

  localparam logic [SEL_W:0] SRC_LIM = (SEL_W+1)'(N_SRC);
  localparam logic [SEL_W:0] DST_LIM = (SEL_W+1)'(N_DST);

  function automatic logic [N_SRC-1:0] src_onehot(input logic [SEL_W-1:0] idx);
    logic [N_SRC-1:0] v;
    for (int i = 0; i < N_SRC; i++) v[i] = (idx == SEL_W'(i));
    return v;
  endfunction

  function automatic logic [N_DST-1:0] dst_onehot(input logic [SEL_W-1:0] idx);
    logic [N_DST-1:0] v;
    for (int i = 0; i < N_DST; i++) v[i] = (idx == SEL_W'(i));
    return v;
  endfunction

  state_t           r_state;
  logic [SEL_W-1:0] r_dst;
  logic [N_SRC-1:0] r_oe;
  logic [N_DST-1:0] r_ld;
  logic [W-1:0]     r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_req_ok;

  assign w_req_ok = ({1'b0, src} < SRC_LIM) && ({1'b0, dst} < DST_LIM);

  // Transfer sequencer; oe is only ever set leaving IDLE and cleared leaving
  // CAPTURE, so LOAD always separates consecutive drive windows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dst   <= {SEL_W{1'b0}};
      r_oe    <= {N_SRC{1'b0}};
      r_ld    <= {N_DST{1'b0}};
      r_data  <= {W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && w_req_ok) begin
            r_dst   <= dst;
            r_oe    <= src_onehot(src);
            r_busy  <= 1'b1;
            r_state <= S_DRIVE;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        S_DRIVE: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_data  <= bus_in;
          r_oe    <= {N_SRC{1'b0}};
          r_ld    <= dst_onehot(r_dst);
          r_done  <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_ld    <= {N_DST{1'b0}};
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_oe    <= {N_SRC{1'b0}};
          r_ld    <= {N_DST{1'b0}};
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oe       = r_oe;
  assign ld       = r_ld;
  assign data_out = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with three modelled bus-driving registers.
module tb_bus_xfer_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] src;
  logic [1:0] dst;
  wire  [7:0] bus_in;
  logic [2:0] oe;
  logic [3:0] ld;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       err;

  int n_pass = 0;
  int n_chk  = 0;

  bus_xfer_ctrl #(.W(8), .N_SRC(3), .N_DST(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst),
    .bus_in(bus_in), .oe(oe), .ld(ld), .data_out(data_out),
    .busy(busy), .done(done), .err(err)
  );

  // Register 0 holds 3C, register 1 holds FF, register 2 holds A5.
  assign bus_in = oe[2] ? 8'hA5 : (oe[1] ? 8'hFF : (oe[0] ? 8'h3C : 8'hzz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_all(input string tag, input logic [2:0] e_oe, input logic [3:0] e_ld,
                            input logic [7:0] e_data, input logic e_busy,
                            input logic e_done, input logic e_err);
    chk({tag, ".oe"},   32'(oe),       32'(e_oe));
    chk({tag, ".ld"},   32'(ld),       32'(e_ld));
    chk({tag, ".data"}, 32'(data_out), 32'(e_data));
    chk({tag, ".busy"}, 32'(busy),     32'(e_busy));
    chk({tag, ".done"}, 32'(done),     32'(e_done));
    chk({tag, ".err"},  32'(err),      32'(e_err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; src = 2'd2; dst = 2'd1;

    // Reset held two cycles with start asserted
    step(); step();
    expect_all("reset", 3'b000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; start = 1'b0;
    step();
    expect_all("idle0", 3'b000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    expect_all("idle1", 3'b000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);

    // Basic transfer src=2 -> dst=1
    start = 1'b1; src = 2'd2; dst = 2'd1;
    step(); start = 1'b0;
    expect_all("basic_k1", 3'b100, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    expect_all("basic_k2", 3'b100, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    expect_all("basic_k3", 3'b000, 4'b0010, 8'hA5, 1'b1, 1'b1, 1'b0);
    step();
    expect_all("basic_k4", 3'b000, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0);

    // Out-of-range source
    start = 1'b1; src = 2'd3; dst = 2'd0;
    step(); start = 1'b0;
    expect_all("oor_k1", 3'b000, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b1);
    step();
    expect_all("oor_k2", 3'b000, 4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0);

    // start held high: accepts 4 cycles apart
    start = 1'b1; src = 2'd0; dst = 2'd3;
    step();
    expect_all("hold_k1", 3'b001, 4'b0000, 8'hA5, 1'b1, 1'b0, 1'b0);
    step();
    expect_all("hold_k2", 3'b001, 4'b0000, 8'hA5, 1'b1, 1'b0, 1'b0);
    step();
    expect_all("hold_k3", 3'b000, 4'b1000, 8'h3C, 1'b1, 1'b1, 1'b0);
    step();
    expect_all("hold_k4", 3'b000, 4'b0000, 8'h3C, 1'b0, 1'b0, 1'b0);
    step();
    expect_all("hold_k5", 3'b001, 4'b0000, 8'h3C, 1'b1, 1'b0, 1'b0);
    step();
    expect_all("hold_k6", 3'b001, 4'b0000, 8'h3C, 1'b1, 1'b0, 1'b0);
    step(); start = 1'b0;
    expect_all("hold_k7", 3'b000, 4'b1000, 8'h3C, 1'b1, 1'b1, 1'b0);
    step();
    expect_all("hold_k8", 3'b000, 4'b0000, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Reset on the edge that would leave CAPTURE
    start = 1'b1; src = 2'd2; dst = 2'd1;
    step(); start = 1'b0;
    expect_all("mrst_k1", 3'b100, 4'b0000, 8'h3C, 1'b1, 1'b0, 1'b0);
    step();
    expect_all("mrst_k2", 3'b100, 4'b0000, 8'h3C, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    expect_all("mrst_k3", 3'b000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    expect_all("mrst_k4", 3'b000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);

    // Self transfer src=dst=1 after reset
    start = 1'b1; src = 2'd1; dst = 2'd1;
    step(); start = 1'b0;
    expect_all("self_k1", 3'b010, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    expect_all("self_k2", 3'b010, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    expect_all("self_k3", 3'b000, 4'b0010, 8'hFF, 1'b1, 1'b1, 1'b0);
    step();
    expect_all("self_k4", 3'b000, 4'b0000, 8'hFF, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
